multiplier_128bits_seq_ctrl: RTL and testbench

MULTIPLIER_128BITS_SEQ_CTRL -- requirements
Module: multiplier_128bits_seq_ctrl

---
 rtl/multiplier_ctrl_pkg.sv | 25 ++
 rtl/multiplier_64bits_version12.sv | 8 +
 rtl/multiplier_128bits_seq_ctrl.sv | 103 ++++++++++
 tb/tb_multiplier_128bits_seq_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/multiplier_ctrl_pkg.sv
// Shared types and constants for the 128x128 sequential multiplier controller.
package multiplier_ctrl_pkg;
  localparam int CORE_W = 64;
  localparam int PASSES = 4;
  localparam int OPER_W = 2 * CORE_W;
  localparam int PROD_W = 4 * CORE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pass 0 lands at bit 0, passes 1/2 (cross terms) at CORE_W, pass 3 at 2*CORE_W.
  function automatic logic [PROD_W-1:0] align_pp(input logic [2*CORE_W-1:0] pp,
                                                 input logic [1:0] pass);
    logic [PROD_W-1:0] ext;
    ext = {{(PROD_W - 2*CORE_W){1'b0}}, pp};
    case (pass)
      2'd0:    return ext;
      2'd3:    return ext << (2 * CORE_W);
      default: return ext << CORE_W;
    endcase
  endfunction
endpackage

// File: rtl/multiplier_64bits_version12.sv
// 64x64 unsigned combinational multiplier core, time-shared by the controller.
module multiplier_64bits_version12 (
  input  logic [63:0]  A,
  input  logic [63:0]  B,
  output logic [127:0] product
);
  assign product = A * B;
endmodule

// File: rtl/multiplier_128bits_seq_ctrl.sv
// 128x128 unsigned multiplier: four passes through one 64x64 core, result held until done_ready.
// Latency 4 cycles (PIPE_CORE=0) or 5 cycles (PIPE_CORE=1) from start handshake to done_valid.
module multiplier_128bits_seq_ctrl
  import multiplier_ctrl_pkg::*;
#(
  parameter int PIPE_CORE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [127:0]  A,
  input  logic [127:0]  B,
  output logic [255:0]  product,
  output logic          done_valid,
  input  logic          done_ready,
  output logic          busy
);
  state_t              state;
  logic [1:0]          cnt;
  logic [OPER_W-1:0]   a_q, b_q;
  logic [PROD_W-1:0]   acc;
  logic [CORE_W-1:0]   core_a, core_b;
  logic [2*CORE_W-1:0] pp, pp_q;
  logic [1:0]          pass_q;
  logic                pp_vld, drain;
  logic                start_fire, last_pass;

  assign core_a      = cnt[1] ? a_q[OPER_W-1:CORE_W] : a_q[CORE_W-1:0];
  assign core_b      = cnt[0] ? b_q[OPER_W-1:CORE_W] : b_q[CORE_W-1:0];
  assign start_ready = (state == IDLE) || ((state == DONE) && done_ready);
  assign start_fire  = start_valid && start_ready;
  assign last_pass   = (cnt == 2'(PASSES - 1));
  assign product     = acc;

  multiplier_64bits_version12 u_core (
    .product (pp),
    .A       (core_a),
    .B       (core_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      a_q        <= '0;
      b_q        <= '0;
      acc        <= '0;
      pp_q       <= '0;
      pass_q     <= 2'd0;
      pp_vld     <= 1'b0;
      drain      <= 1'b0;
      done_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (start_fire) begin
      a_q        <= A;
      b_q        <= B;
      acc        <= '0;
      cnt        <= 2'd0;
      pp_vld     <= 1'b0;
      drain      <= 1'b0;
      done_valid <= 1'b0;
      busy       <= 1'b1;
      state      <= MUL;
    end else begin
      case (state)
        IDLE: ;
        MUL: begin
          if (PIPE_CORE == 0) begin
            acc <= acc + align_pp(pp, cnt);
            cnt <= cnt + 2'd1;
            if (last_pass) begin
              state      <= DONE;
              busy       <= 1'b0;
              done_valid <= 1'b1;
            end
          end else begin
            // Registered core output is folded in one cycle after issue; drain covers the last pass.
            if (pp_vld) acc <= acc + align_pp(pp_q, pass_q);
            pp_q   <= pp;
            pass_q <= cnt;
            pp_vld <= !drain;
            if (!drain) begin
              cnt <= cnt + 2'd1;
              if (last_pass) drain <= 1'b1;
            end else if (pp_vld) begin
              state      <= DONE;
              busy       <= 1'b0;
              done_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiplier_128bits_seq_ctrl.sv
// Directed self-checking bench: one instance per PIPE_CORE value, shared clock, reset and operands.
module tb_multiplier_128bits_seq_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] mul_a, mul_b;
  logic         sv0, sv1, dr0, dr1;
  logic         sr0, sr1, dv0, dv1, bz0, bz1;
  logic [255:0] p0, p1;
  int           n_cmp = 0;
  int           n_err = 0;

  localparam logic [127:0] ALL1  = {128{1'b1}};
  localparam logic [255:0] MAXSQ = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFE00000000000000000000000000000001;
  localparam logic [255:0] P3X64 = 256'h30000000000000000;

  always #5 clk = ~clk;

  multiplier_128bits_seq_ctrl #(.PIPE_CORE(0)) dut0 (
    .clk(clk), .rst(rst), .start_valid(sv0), .start_ready(sr0), .A(mul_a), .B(mul_b),
    .product(p0), .done_valid(dv0), .done_ready(dr0), .busy(bz0)
  );

  multiplier_128bits_seq_ctrl #(.PIPE_CORE(1)) dut1 (
    .clk(clk), .rst(rst), .start_valid(sv1), .start_ready(sr1), .A(mul_a), .B(mul_b),
    .product(p1), .done_valid(dv1), .done_ready(dr1), .busy(bz1)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    mul_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    mul_b = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Handshake one operand pair into the selected instance and check result and latency.
  task automatic run_op(input int sel, input logic [127:0] a, input logic [127:0] b,
                        input logic [255:0] exp, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    mul_a = a;
    mul_b = b;
    if (sel == 0) sv0 = 1'b1; else sv1 = 1'b1;
    chk({tag, "_start_ready"}, (sel == 0) ? sr0 : sr1, 1'b1);
    tick();
    sv0 = 1'b0;
    sv1 = 1'b0;
    scramble();
    chk({tag, "_busy"}, (sel == 0) ? bz0 : bz1, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (((sel == 0) ? dv0 : dv1) === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_product"}, (sel == 0) ? p0 : p1, exp);
  endtask

  task automatic retire(input int sel, input string tag);
    if (sel == 0) dr0 = 1'b1; else dr1 = 1'b1;
    tick();
    dr0 = 1'b0;
    dr1 = 1'b0;
    chk({tag, "_done_low"}, (sel == 0) ? dv0 : dv1, 1'b0);
    chk({tag, "_idle_ready"}, (sel == 0) ? sr0 : sr1, 1'b1);
  endtask

  initial begin
    int seen_dv;
    rst = 1'b1;
    sv0 = 1'b0; sv1 = 1'b0; dr0 = 1'b0; dr1 = 1'b0;
    mul_a = '0; mul_b = '0;
    tick();
    tick();
    chk("rst_product", p0, 256'd0);
    chk("rst_done_valid", dv0, 1'b0);
    chk("rst_busy", bz0, 1'b0);
    rst = 1'b0;
    tick();
    chk("post_rst_start_ready", sr0, 1'b1);
    chk("post_rst_start_ready_pipe", sr1, 1'b1);

    run_op(0, 128'd1, 128'd1, 256'd1, 4, "one_by_one");
    chk("one_by_one_busy_done", bz0, 1'b0);
    retire(0, "one_by_one");

    run_op(0, ALL1, ALL1, MAXSQ, 4, "max_sq");
    retire(0, "max_sq");

    run_op(0, 128'h1 << 64, 128'd3, P3X64, 4, "shift64_p0");
    retire(0, "shift64_p0");
    run_op(1, 128'h1 << 64, 128'd3, P3X64, 5, "shift64_p1");
    retire(1, "shift64_p1");
    run_op(1, ALL1, ALL1, MAXSQ, 5, "max_sq_p1");
    retire(1, "max_sq_p1");

    // Result held under backpressure while a new start is pending.
    run_op(0, 128'd6, 128'd7, 256'd42, 4, "hold");
    mul_a = 128'd9;
    mul_b = 128'd9;
    sv0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_done_valid", dv0, 1'b1);
      chk("hold_product", p0, 256'd42);
      chk("hold_start_ready", sr0, 1'b0);
      chk("hold_busy", bz0, 1'b0);
    end

    // Simultaneous done and start handshake: straight back into MUL.
    mul_a = 128'd11;
    mul_b = 128'd13;
    dr0 = 1'b1;
    #1;
    chk("b2b_start_ready", sr0, 1'b1);
    tick();
    sv0 = 1'b0;
    dr0 = 1'b0;
    scramble();
    chk("b2b_done_low", dv0, 1'b0);
    chk("b2b_busy", bz0, 1'b1);
    seen_dv = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (dv0 === 1'b1) begin
        seen_dv = i;
        break;
      end
    end
    chk("b2b_latency", seen_dv, 4);
    chk("b2b_product", p0, 256'd143);
    retire(0, "b2b");

    // Reset pulse in the middle of an operation (after two passes, cnt=2).
    mul_a = ALL1;
    mul_b = 128'h1234_5678;
    sv0 = 1'b1;
    tick();
    sv0 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_product", p0, 256'd0);
    chk("abort_done_valid", dv0, 1'b0);
    chk("abort_busy", bz0, 1'b0);
    chk("abort_start_ready", sr0, 1'b1);
    tick();
    rst = 1'b0;
    seen_dv = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dv0 !== 1'b0) seen_dv = 1;
    end
    chk("abort_no_done", seen_dv, 0);
    run_op(0, 128'd5, 128'd7, 256'd35, 4, "after_abort");
    retire(0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
